// File: rtl/muldiv_unit_if.sv
// Start/done handshake bundle between the EX stage and the multiply/divide unit.
// master drives requests; slave is the unit itself.
interface muldiv_unit_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic                  start;
  logic [2:0]            op;
  logic [DATA_W-1:0]     a_i;
  logic [DATA_W-1:0]     b_i;
  logic [2*DATA_W-1:0]   hilo_i;
  logic                  cancel;
  logic                  busy;
  logic                  done;
  logic [DATA_W-1:0]     hi_o;
  logic [DATA_W-1:0]     lo_o;
  logic                  dbz;

  modport master (
    output start, op, a_i, b_i, hilo_i, cancel,
    input  busy, done, hi_o, lo_o, dbz
  );

  modport slave (
    input  start, op, a_i, b_i, hilo_i, cancel,
    output busy, done, hi_o, lo_o, dbz
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MADD/MSUB/DIV unit with a fixed-latency multiplier and a
// restoring divider; produces a {hi,lo} pair with a one-cycle done pulse.
module muldiv_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);
  localparam int unsigned PROD_W  = 2 * DATA_W;
  localparam int unsigned CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          acc_q, acc_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   araw_q, araw_d;
  logic [PROD_W-1:0]   hilo_q, hilo_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic                in_sgn;
  logic [PROD_W-1:0]   prod;
  logic [PROD_W-1:0]   prod_s;
  logic [PROD_W-1:0]   mul_res;
  logic [DATA_W:0]     trial;

  // Magnitude of a possibly-signed operand; most-negative maps to 2^(W-1).
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic sgn);
    return (sgn && x[DATA_W-1]) ? -x : x;
  endfunction

  assign in_sgn = ~bus.op[0];

  // Multiply/accumulate and divider-step datapath, all from latched operands.
  always_comb begin
    prod   = PROD_W'(a_q) * PROD_W'(b_q);
    prod_s = neg_q ? -prod : prod;
    case (acc_q)
      2'b01:   mul_res = hilo_q + prod_s;
      2'b10:   mul_res = hilo_q - prod_s;
      default: mul_res = prod_s;
    endcase
    trial = {rem_q, a_q[DATA_W-1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      araw_q  <= '0;
      hilo_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      araw_q  <= araw_d;
      hilo_q  <= hilo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state and next-output logic; cancel overrides everything last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    araw_d  = araw_q;
    hilo_d  = hilo_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.cancel) begin
          acc_d   = bus.op[2:1];
          neg_d   = in_sgn & (bus.a_i[DATA_W-1] ^ bus.b_i[DATA_W-1]);
          rneg_d  = in_sgn & bus.a_i[DATA_W-1];
          a_d     = mag(bus.a_i, in_sgn);
          b_d     = mag(bus.b_i, in_sgn);
          araw_d  = bus.a_i;
          hilo_d  = bus.hilo_i;
          rem_d   = '0;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          state_d = (bus.op[2] && bus.op[1]) ? DIV : MUL;
        end
      end
      MUL: begin
        if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
          state_d      = DONE;
          done_d       = 1'b1;
          {hi_d, lo_d} = mul_res;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DIV: begin
        if (b_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          dbz_d   = 1'b1;
          hi_d    = araw_q;
          lo_d    = {DATA_W{1'b1}};
        end else if (cnt_q == CNT_W'(DATA_W)) begin
          state_d = DONE;
          done_d  = 1'b1;
          lo_d    = neg_q  ? -a_q   : a_q;
          hi_d    = rneg_q ? -rem_q : rem_q;
        end else begin
          // a_q shifts out dividend bits and shifts in quotient bits.
          if (trial >= {1'b0, b_q}) begin
            rem_d = DATA_W'(trial - {1'b0, b_q});
            a_d   = {a_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = trial[DATA_W-1:0];
            a_d   = {a_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.cancel) begin
      state_d = IDLE;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;
  assign bus.hi_o = hi_q;
  assign bus.lo_o = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table through a scoreboard on a 32-bit/MUL_LAT=2
// instance, plus hand sequences and an 8-bit/MUL_LAT=1 instance.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst8_n = 1'b0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit_if #(.DATA_W(32)) bus ();
  muldiv_unit_if #(.DATA_W(8))  bus8 ();

  muldiv_unit #(.DATA_W(32), .MUL_LAT(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  muldiv_unit #(.DATA_W(8),  .MUL_LAT(1)) dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8.slave));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] hilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int unsigned lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int unsigned cyc;
  } exp_t;

  localparam int NV = 16;
  vec_t vt[NV];
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request for a single cycle and record its expected result.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] hilo, input logic [31:0] hi, input logic [31:0] lo,
                       input logic dbz, input int unsigned lat);
    exp_t e;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.a_i    = a;
    bus.b_i    = b;
    bus.hilo_i = hilo;
    e.hi  = hi;
    e.lo  = lo;
    e.dbz = dbz;
    e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done, compare against the scoreboard head, check the pulse ends.
  task automatic await_done(input string name, input int unsigned budget, input bit restart);
    exp_t e;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < int'(budget) && !seen; i++) begin
      @(negedge clk);
      seen = bus.done;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
      if (sb.size() > 0) e = sb.pop_front();
      return;
    end
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_unexpected: done with empty scoreboard", name);
      return;
    end
    e = sb.pop_front();
    check({name, "_lat"}, 64'(cyc), 64'(e.cyc));
    check({name, "_hi"},  64'(bus.hi_o), 64'(e.hi));
    check({name, "_lo"},  64'(bus.lo_o), 64'(e.lo));
    check({name, "_dbz"}, 64'(bus.dbz), 64'(e.dbz));
    if (restart) begin
      bus.start = 1'b1;
      bus.op    = 3'd1;
      bus.a_i   = 32'd9;
      bus.b_i   = 32'd9;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check({name, "_pulse"}, 64'(bus.done), 64'd0);
    check({name, "_idle"},  64'(bus.busy), 64'd0);
  endtask

  task automatic wait8(input int unsigned budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < int'(budget) && !seen; i++) begin
      @(negedge clk);
      seen = bus8.done;
    end
  endtask

  initial begin
    int unsigned e0;
    int ndone;
    bit seen;

    vt[0]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        64'd0,                  32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 2};
    vt[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0,                  32'hFFFFFFFE, 32'h00000001, 1'b0, 2};
    vt[2]  = '{3'd3, 32'd1,        32'd1,        64'h00000001_FFFFFFFF,  32'h00000002, 32'h00000000, 1'b0, 2};
    vt[3]  = '{3'd4, 32'd1,        32'd1,        64'h00000001_FFFFFFFF,  32'h00000001, 32'hFFFFFFFE, 1'b0, 2};
    vt[4]  = '{3'd2, 32'hFFFFFFFE, 32'd3,        64'd0,                  32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 2};
    vt[5]  = '{3'd5, 32'd1,        32'd1,        64'd0,                  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2};
    vt[6]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        64'd0,                  32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vt[7]  = '{3'd7, 32'd7,        32'd2,        64'd0,                  32'h00000001, 32'h00000003, 1'b0, 33};
    vt[8]  = '{3'd6, 32'd7,        32'hFFFFFFFE, 64'd0,                  32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
    vt[9]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 64'd0,                  32'h00000000, 32'h80000000, 1'b0, 33};
    vt[10] = '{3'd7, 32'h00001234, 32'd0,        64'd0,                  32'h00001234, 32'hFFFFFFFF, 1'b1, 1};
    vt[11] = '{3'd6, 32'hFFFFFFFB, 32'd0,        64'd0,                  32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1};
    vt[12] = '{3'd7, 32'hFFFFFFFF, 32'h10,       64'd0,                  32'h0000000F, 32'h0FFFFFFF, 1'b0, 33};
    vt[13] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hDEAD_BEEF_0000_0000, 32'h00000000, 32'h00000001, 1'b0, 2};
    vt[14] = '{3'd2, 32'hFFFFFFFF, 32'd2,        64'h00000000_00000005,  32'h00000000, 32'h00000003, 1'b0, 2};
    vt[15] = '{3'd6, 32'hFFFFFFF8, 32'hFFFFFFFD, 64'd0,                  32'hFFFFFFFE, 32'h00000002, 1'b0, 33};

    bus.start = 1'b0;  bus.op = 3'd0;  bus.a_i = '0;  bus.b_i = '0;  bus.hilo_i = '0;  bus.cancel = 1'b0;
    bus8.start = 1'b0; bus8.op = 3'd0; bus8.a_i = '0; bus8.b_i = '0; bus8.hilo_i = '0; bus8.cancel = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_dbz",  64'(bus.dbz),  64'd0);
    check("rst_hi",   64'(bus.hi_o), 64'd0);
    check("rst_lo",   64'(bus.lo_o), 64'd0);
    rst_n  = 1'b1;
    rst8_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].hilo, vt[i].hi, vt[i].lo, vt[i].dbz, vt[i].lat);
      await_done($sformatf("v%0d", i), 40, 1'b0);
    end

    // dbz holds in IDLE and clears on the next accepted start.
    issue(3'd7, 32'h00001234, 32'd0, 64'd0, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1);
    await_done("dbz", 10, 1'b0);
    check("dbz_hold", 64'(bus.dbz), 64'd1);
    issue(3'd1, 32'd2, 32'd3, 64'd0, 32'd0, 32'd6, 1'b0, 2);
    check("dbz_clear", 64'(bus.dbz), 64'd0);
    check("dbz_busy",  64'(bus.busy), 64'd1);
    await_done("after_dbz", 10, 1'b0);

    // A start while busy is ignored; the divide result is unaffected.
    issue(3'd7, 32'd100, 32'd7, 64'd0, 32'd2, 32'd14, 1'b0, 33);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd1; bus.a_i = 32'd5; bus.b_i = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_busy", 64'(bus.busy), 64'd1);
    await_done("ign", 40, 1'b0);

    // Cancel at divide iteration 10: no done, hi/lo retained.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd6; bus.a_i = 32'hFFFFFFF9; bus.b_i = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.start = (i == 3);
      bus.op    = 3'd1;
    end
    bus.start  = 1'b0;
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_busy", 64'(bus.busy), 64'd0);
    ndone = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("cancel_nodone", 64'(ndone), 64'd0);
    check("cancel_hi", 64'(bus.hi_o), 64'd2);
    check("cancel_lo", 64'(bus.lo_o), 64'd14);

    // A start presented during the DONE cycle is dropped.
    issue(3'd1, 32'd3, 32'd4, 64'd0, 32'd0, 32'd12, 1'b0, 2);
    await_done("done_start", 10, 1'b1);
    @(negedge clk);
    check("done_start_idle", 64'(bus.busy), 64'd0);

    // start together with cancel in IDLE is dropped.
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 3'd1;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    check("start_cancel_busy", 64'(bus.busy), 64'd0);
    check("start_cancel_lo", 64'(bus.lo_o), 64'd12);

    // 8-bit instance: most-negative / -1 and single-cycle multiply.
    @(negedge clk);
    bus8.start = 1'b1; bus8.op = 3'd6; bus8.a_i = 8'h80; bus8.b_i = 8'hFF;
    @(negedge clk);
    bus8.start = 1'b0;
    e0 = cyc;
    wait8(20, seen);
    check("w8_div_seen", 64'(seen), 64'd1);
    check("w8_div_lat", 64'(cyc), 64'(e0 + 9));
    check("w8_div_lo", 64'(bus8.lo_o), 64'h80);
    check("w8_div_hi", 64'(bus8.hi_o), 64'h00);
    check("w8_div_dbz", 64'(bus8.dbz), 64'd0);

    @(negedge clk);
    bus8.start = 1'b1; bus8.op = 3'd0; bus8.a_i = 8'h80; bus8.b_i = 8'h80;
    @(negedge clk);
    bus8.start = 1'b0;
    e0 = cyc;
    wait8(10, seen);
    check("w8_mul_seen", 64'(seen), 64'd1);
    check("w8_mul_lat", 64'(cyc), 64'(e0 + 1));
    check("w8_mul_hi", 64'(bus8.hi_o), 64'h40);
    check("w8_mul_lo", 64'(bus8.lo_o), 64'h00);

    // Reset in the middle of a divide clears every output.
    @(negedge clk);
    @(negedge clk);
    bus8.start = 1'b1; bus8.op = 3'd7; bus8.a_i = 8'hFF; bus8.b_i = 8'h03;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("w8_pre_rst_busy", 64'(bus8.busy), 64'd1);
    rst8_n = 1'b0;
    @(negedge clk);
    check("w8_rst_busy", 64'(bus8.busy), 64'd0);
    check("w8_rst_done", 64'(bus8.done), 64'd0);
    check("w8_rst_hi",   64'(bus8.hi_o), 64'd0);
    check("w8_rst_lo",   64'(bus8.lo_o), 64'd0);
    check("w8_rst_dbz",  64'(bus8.dbz),  64'd0);
    rst8_n = 1'b1;

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
